lock_ctrl: RTL and testbench

Sequencing controller for the push-button code lock. It edge-detects the two buttons, collects a CODE_LEN-digit entry and compares it against a programmable code. It times the unlock window, counts failed attempts, and enforces a timed lockout after MAX_FAIL consecutive failures. It sits between the raw (already synchronised) button inputs and the lock actuator, and also exposes status to a front panel.

---
 rtl/lock_pkg.sv | 30 +++
 rtl/lock_ctrl_if.sv | 38 +++
 rtl/btn_edge.sv | 29 ++
 rtl/lock_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lock_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the push-button code lock and the sequence-detector
// FSM that already uses the same default code.
//   state_t      : controller state encodings (3-bit, 5 legal values)
//   DEF_CODE_LEN : default digits per code entry
//   DEF_CODE     : default reset-value code, MSB is the first digit entered
//   clog2()      : width helper, never returns less than 1
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int DEF_CODE_LEN = 4;
  localparam logic [DEF_CODE_LEN-1:0] DEF_CODE = 4'b1011;

  // Bits needed to hold values 0..value-1; a width of 0 is never returned.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Front-panel / actuator bundle of the code lock controller.
//   button_1, button_0 : synchronised button levels (rising edge = digit)
//   cfg_we, cfg_code   : request to replace the stored code
//   unlock             : lock actuator drive
//   locked_out         : lockout indicator
//   err                : one-cycle pulse on each failed attempt
//   fail_cnt           : consecutive failure count
//   digit_cnt          : digits collected in the current entry
// master = panel side (drives buttons/config), slave = controller.
interface lock_ctrl_if
  import lock_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN
) ();

  localparam int DCW = clog2(CODE_LEN + 1);

  logic                button_1;
  logic                button_0;
  logic                cfg_we;
  logic [CODE_LEN-1:0] cfg_code;
  logic                unlock;
  logic                locked_out;
  logic                err;
  logic [3:0]          fail_cnt;
  logic [DCW-1:0]      digit_cnt;

  modport master (
    output button_1, button_0, cfg_we, cfg_code,
    input  unlock, locked_out, err, fail_cnt, digit_cnt
  );

  modport slave (
    input  button_1, button_0, cfg_we, cfg_code,
    output unlock, locked_out, err, fail_cnt, digit_cnt
  );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronised button level.
//   clk, reset_n : clock and synchronous active-low reset
//   button       : button level
//   press        : registered one-cycle pulse per rising edge
// A button already held when reset is released produces no pulse: the arm
// flag blocks the first post-reset cycle while prev picks up the level.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic press
);

  logic prev;
  logic arm;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev  <= 1'b0;
      arm   <= 1'b0;
      press <= 1'b0;
    end else begin
      prev  <= button;
      arm   <= 1'b1;
      press <= button & ~prev & arm;
    end
  end

endmodule

// File: rtl/lock_ctrl.sv
// Sequencing controller for the push-button code lock.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   bus     : lock_ctrl_if slave (buttons, code config, unlock/lockout status)
// Collects CODE_LEN digits (MSB first), compares them with the code register,
// drives unlock for UNLOCK_CYCLES on a match, counts consecutive failures and
// holds a LOCKOUT_CYCLES lockout after MAX_FAIL of them. A partial entry is
// dropped after TIMEOUT_CYCLES clocks without a press.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN       = DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE           = DEF_CODE,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  UNLOCK_CYCLES  = 500,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  TIMEOUT_CYCLES = 200
) (
  input logic        clk,
  input logic        reset_n,
  lock_ctrl_if.slave bus
);

  localparam int TMAX =
    (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
      ((UNLOCK_CYCLES > TIMEOUT_CYCLES) ? UNLOCK_CYCLES : TIMEOUT_CYCLES) :
      ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
  localparam int TW  = clog2(TMAX + 1);
  localparam int DCW = clog2(CODE_LEN + 1);

  // Timers load N-1 and expire when they are seen at 0, giving N cycles.
  localparam logic [TW-1:0]  T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0]  T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0]  T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  T_ONE     = TW'(1);
  localparam logic [DCW-1:0] DC_ONE    = DCW'(1);
  localparam logic [DCW-1:0] DC_LAST   = DCW'(CODE_LEN - 1);
  localparam logic [3:0]     FAIL_MAX  = 4'(MAX_FAIL);

  state_t              state;
  logic [CODE_LEN-1:0] sreg;
  logic [CODE_LEN-1:0] code_reg;
  logic [DCW-1:0]      digit_cnt;
  logic [3:0]          fail_cnt;
  logic [3:0]          fail_inc;
  logic [TW-1:0]       timer;
  logic                invalid;
  logic                unlock;
  logic                locked_out;
  logic                err;
  logic                p1;
  logic                p0;

  btn_edge u_btn_1 (
    .clk     (clk),
    .reset_n (reset_n),
    .button  (bus.button_1),
    .press   (p1)
  );

  btn_edge u_btn_0 (
    .clk     (clk),
    .reset_n (reset_n),
    .button  (bus.button_0),
    .press   (p0)
  );

  // Saturating failure increment; lockout clears the count before it can
  // exceed MAX_FAIL, the clamp only guards against wrapping.
  assign fail_inc = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      code_reg   <= CODE;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      timer      <= '0;
      invalid    <= 1'b0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE, ST_ENTRY: begin
          if (p1 && p0) begin
            // Both buttons in one cycle: fail through CHECK next cycle.
            invalid <= 1'b1;
            state   <= ST_CHECK;
          end else if (p1 || p0) begin
            sreg      <= {sreg[CODE_LEN-2:0], p1};
            digit_cnt <= digit_cnt + DC_ONE;
            timer     <= T_TIMEOUT;
            state     <= (digit_cnt == DC_LAST) ? ST_CHECK : ST_ENTRY;
          end else if (state == ST_ENTRY) begin
            if (timer == '0) begin
              // Abandoned partial entry: discard silently.
              state     <= ST_IDLE;
              sreg      <= '0;
              digit_cnt <= '0;
            end else begin
              timer <= timer - T_ONE;
            end
          end
        end

        ST_CHECK: begin
          invalid   <= 1'b0;
          sreg      <= '0;
          digit_cnt <= '0;
          if (!invalid && (sreg == code_reg)) begin
            state    <= ST_OPEN;
            unlock   <= 1'b1;
            fail_cnt <= '0;
            timer    <= T_UNLOCK;
          end else begin
            err      <= 1'b1;
            fail_cnt <= fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state      <= ST_LOCKOUT;
              locked_out <= 1'b1;
              timer      <= T_LOCKOUT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_OPEN: begin
          // Only window in which the code may be replaced.
          if (bus.cfg_we) code_reg <= bus.cfg_code;
          if (timer == '0) begin
            unlock <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        ST_LOCKOUT: begin
          if (timer == '0) begin
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            state      <= ST_IDLE;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        default: begin
          state      <= ST_IDLE;
          sreg       <= '0;
          digit_cnt  <= '0;
          fail_cnt   <= '0;
          timer      <= '0;
          invalid    <= 1'b0;
          unlock     <= 1'b0;
          locked_out <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlock     = unlock;
  assign bus.locked_out = locked_out;
  assign bus.err        = err;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.digit_cnt  = digit_cnt;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl with CODE_LEN=4, CODE=1011, MAX_FAIL=3,
// UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, TIMEOUT_CYCLES=10.
// Each code entry pushes its expected outcome (unlock or err + fail_cnt) to a
// queue; a negedge monitor pops it when the DUT raises unlock or pulses err.
module tb_lock_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  lock_ctrl_if #(.CODE_LEN(4)) bus ();

  lock_ctrl #(
    .CODE_LEN       (4),
    .CODE           (4'b1011),
    .MAX_FAIL       (3),
    .UNLOCK_CYCLES  (8),
    .LOCKOUT_CYCLES (16),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int un_total = 0;
  int lo_total = 0;
  logic unlock_q = 1'b0;

  typedef struct packed {
    logic       is_err;
    logic [3:0] fail;
  } sb_t;
  sb_t sb_q[$];

  typedef struct packed {
    logic [3:0] code;
    logic       exp_unlock;
    logic [3:0] exp_fail;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_unlock();
    sb_q.push_back('{is_err: 1'b0, fail: 4'd0});
  endtask

  task automatic push_err(input logic [3:0] fail);
    sb_q.push_back('{is_err: 1'b1, fail: fail});
  endtask

  task automatic sb_pop(input logic is_err);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got %s with fail_cnt=%0d, expected no event",
               is_err ? "err" : "unlock", bus.fail_cnt);
    end else begin
      e = sb_q.pop_front();
      if (e.is_err !== is_err || e.fail !== bus.fail_cnt) begin
        failures++;
        $display("FAIL sb_event: got is_err=%0b fail_cnt=%0d expected is_err=%0b fail_cnt=%0d",
                 is_err, bus.fail_cnt, e.is_err, e.fail);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.unlock && !unlock_q) sb_pop(1'b0);
      if (bus.err) sb_pop(1'b1);
    end
    unlock_q = bus.unlock;
    if (bus.unlock) un_total = un_total + 1;
    if (bus.locked_out) lo_total = lo_total + 1;
  end

  task automatic press(input logic d, input int gap);
    if (d) bus.button_1 = 1'b1;
    else   bus.button_0 = 1'b1;
    tick();
    bus.button_1 = 1'b0;
    bus.button_0 = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic enter(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) press(code[i], 1);
  endtask

  task automatic wait_unlock(input logic want, input int budget, input string name);
    int n;
    n = 0;
    while (bus.unlock !== want && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.unlock !== want) begin
      failures++;
      $display("FAIL %s: unlock=%0b after %0d cycles, expected %0b", name, bus.unlock, n, want);
    end
  endtask

  task automatic wait_locked(input logic want, input int budget, input string name);
    int n;
    n = 0;
    while (bus.locked_out !== want && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.locked_out !== want) begin
      failures++;
      $display("FAIL %s: locked_out=%0b after %0d cycles, expected %0b", name, bus.locked_out, n, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    int l0;
    logic [3:0] maxd;

    reset_n      = 1'b0;
    bus.button_1 = 1'b0;
    bus.button_0 = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_code = 4'b0000;
    repeat (3) tick();

    // Reset state
    check1("rst_unlock", bus.unlock, 1'b0);
    check1("rst_locked", bus.locked_out, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check4("rst_fail", bus.fail_cnt, 4'd0);
    check4("rst_digit", {1'b0, bus.digit_cnt}, 4'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Table of entries against code 1011
    vecs[0] = '{code: 4'b1111, exp_unlock: 1'b0, exp_fail: 4'd1};
    vecs[1] = '{code: 4'b0000, exp_unlock: 1'b0, exp_fail: 4'd2};
    vecs[2] = '{code: 4'b1011, exp_unlock: 1'b1, exp_fail: 4'd0};
    vecs[3] = '{code: 4'b1010, exp_unlock: 1'b0, exp_fail: 4'd1};
    vecs[4] = '{code: 4'b1011, exp_unlock: 1'b1, exp_fail: 4'd0};
    vecs[5] = '{code: 4'b0011, exp_unlock: 1'b0, exp_fail: 4'd1};
    vecs[6] = '{code: 4'b1110, exp_unlock: 1'b0, exp_fail: 4'd2};
    vecs[7] = '{code: 4'b1011, exp_unlock: 1'b1, exp_fail: 4'd0};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_unlock) push_unlock();
      else                    push_err(vecs[i].exp_fail);
      enter(vecs[i].code);
      if (vecs[i].exp_unlock) begin
        wait_unlock(1'b1, 4, "tbl_open");
        wait_unlock(1'b0, 20, "tbl_close");
        tick();
      end else begin
        repeat (3) tick();
      end
      check4("tbl_fail", bus.fail_cnt, vecs[i].exp_fail);
      check4("tbl_digit", {1'b0, bus.digit_cnt}, 4'd0);
      check1("tbl_locked", bus.locked_out, 1'b0);
    end

    // Correct code with 3-cycle gaps: latency and window length
    push_unlock();
    press(1'b1, 3);
    press(1'b0, 3);
    press(1'b1, 3);
    check4("open_digits", {1'b0, bus.digit_cnt}, 4'd3);
    u0 = un_total;
    bus.button_1 = 1'b1;
    tick();
    bus.button_1 = 1'b0;
    tick();
    check1("lat_edge1", bus.unlock, 1'b0);
    tick();
    check1("lat_edge2", bus.unlock, 1'b1);
    wait_unlock(1'b0, 20, "open_close");
    check_int("open_len", un_total - u0, 8);
    check4("open_fail", bus.fail_cnt, 4'd0);
    tick();

    // Partial entry timeout
    press(1'b1, 1);
    press(1'b0, 1);
    check4("to_partial", {1'b0, bus.digit_cnt}, 4'd2);
    repeat (8) tick();
    check4("to_hold", {1'b0, bus.digit_cnt}, 4'd2);
    repeat (3) tick();
    check4("to_clear", {1'b0, bus.digit_cnt}, 4'd0);
    check4("to_fail", bus.fail_cnt, 4'd0);
    push_unlock();
    enter(4'b1011);
    wait_unlock(1'b1, 4, "to_open");
    wait_unlock(1'b0, 20, "to_close");
    tick();

    // Three failures -> lockout; correct code ignored during lockout
    l0 = lo_total;
    for (int k = 1; k <= 3; k++) begin
      push_err(4'(k));
      enter(4'b1111);
      if (k < 3) begin
        repeat (3) tick();
        check4("lo_fail_step", bus.fail_cnt, 4'(k));
      end
    end
    wait_locked(1'b1, 4, "lo_enter");
    check4("lo_fail_max", bus.fail_cnt, 4'd3);
    enter(4'b1011);
    check4("lo_ignore_digit", {1'b0, bus.digit_cnt}, 4'd0);
    check1("lo_ignore_unlock", bus.unlock, 1'b0);
    wait_locked(1'b0, 30, "lo_exit");
    check_int("lo_len", lo_total - l0, 16);
    check4("lo_exit_fail", bus.fail_cnt, 4'd0);
    repeat (4) tick();
    check1("lo_after_unlock", bus.unlock, 1'b0);

    // Code change: ignored outside OPEN, taken inside OPEN
    bus.cfg_we   = 1'b1;
    bus.cfg_code = 4'b0000;
    tick();
    bus.cfg_we = 1'b0;
    push_unlock();
    enter(4'b1011);
    wait_unlock(1'b1, 4, "cfg_open");
    bus.cfg_we   = 1'b1;
    bus.cfg_code = 4'b0110;
    tick();
    bus.cfg_we = 1'b0;
    wait_unlock(1'b0, 20, "cfg_close");
    tick();
    push_err(4'd1);
    enter(4'b1011);
    repeat (3) tick();
    check4("cfg_old_fail", bus.fail_cnt, 4'd1);
    push_unlock();
    enter(4'b0110);
    wait_unlock(1'b1, 4, "cfg_new_open");
    wait_unlock(1'b0, 20, "cfg_new_close");
    tick();
    check4("cfg_new_fail", bus.fail_cnt, 4'd0);

    // Simultaneous buttons after one digit, then a long hold
    push_err(4'd1);
    press(1'b1, 2);
    bus.button_1 = 1'b1;
    bus.button_0 = 1'b1;
    tick();
    bus.button_1 = 1'b0;
    bus.button_0 = 1'b0;
    repeat (3) tick();
    check4("both_fail", bus.fail_cnt, 4'd1);
    check4("both_digit", {1'b0, bus.digit_cnt}, 4'd0);
    maxd = 4'd0;
    bus.button_1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({1'b0, bus.digit_cnt} > maxd) maxd = {1'b0, bus.digit_cnt};
    end
    bus.button_1 = 1'b0;
    repeat (2) tick();
    check4("hold_single", maxd, 4'd1);
    check4("hold_release_digit", {1'b0, bus.digit_cnt}, 4'd0);
    check4("hold_fail", bus.fail_cnt, 4'd1);

    // Reset mid-OPEN
    push_unlock();
    enter(4'b0110);
    wait_unlock(1'b1, 4, "rst_open");
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    check1("rst_open_unlock", bus.unlock, 1'b0);
    check1("rst_open_locked", bus.locked_out, 1'b0);
    check4("rst_open_fail", bus.fail_cnt, 4'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Reset mid-LOCKOUT
    for (int k = 1; k <= 3; k++) begin
      push_err(4'(k));
      enter(4'b0000);
      if (k < 3) repeat (3) tick();
    end
    wait_locked(1'b1, 4, "rst_lo_enter");
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check1("rst_lo_locked", bus.locked_out, 1'b0);
    check4("rst_lo_fail", bus.fail_cnt, 4'd0);
    check1("rst_lo_unlock", bus.unlock, 1'b0);
    check4("rst_lo_digit", {1'b0, bus.digit_cnt}, 4'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Code register back to 1011 after reset
    push_unlock();
    enter(4'b1011);
    wait_unlock(1'b1, 4, "rst_code_open");
    wait_unlock(1'b0, 20, "rst_code_close");
    repeat (2) tick();

    check_int("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
